// File: rtl/buzzer_lockout.sv
// Quiz buzzer front end: 2-flop sync, per-player debounce, first-press arbitration and lockout.
// Optional false-start tracking is enabled by defining FALSE_START_EN.
module buzzer_lockout #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buzz,
  input  logic       host_arm,
  input  logic       host_clear,
  output logic [3:0] player,
  output logic [1:0] winner_id,
  output logic       armed,
  output logic       locked,
  output logic [3:0] foul
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StLocked} state_e;

  state_e           state_q, state_d;
  logic [3:0]       s1_q, s2_q, db_q, db_prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       player_q, player_d;
  logic [1:0]       winner_id_q, winner_id_d;
  logic [3:0]       rise, elig;
  logic [1:0]       win_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= buzz;
      s2_q      <= s1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (s2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          db_q[i]  <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = db_q & ~db_prev_q;

`ifdef FALSE_START_EN
  logic [3:0] foul_q;

  // Any press while idle marks that player as having jumped the gun for the next round.
  always_ff @(posedge clk) begin
    if (rst || host_clear) begin
      foul_q <= '0;
    end else if (state_q == StIdle) begin
      foul_q <= foul_q | rise;
    end
  end

  assign elig = rise & ~foul_q;
  assign foul = foul_q;
`else
  assign elig = rise;
  assign foul = 4'b0000;
`endif

  always_comb begin
    win_idx = 2'd0;
    // Descending scan so the lowest index present wins a tie.
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) win_idx = 2'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    winner_id_d = winner_id_q;
    unique case (state_q)
      StIdle: begin
        if (host_arm && !host_clear) state_d = StArmed;
      end
      StArmed: begin
        if (host_clear) begin
          state_d = StIdle;
        end else if (|elig) begin
          state_d     = StLocked;
          player_d    = 4'b0001 << win_idx;
          winner_id_d = win_idx;
        end
      end
      StLocked: begin
        if (host_clear) begin
          state_d     = StIdle;
          player_d    = '0;
          winner_id_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      player_q    <= '0;
      winner_id_q <= '0;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      winner_id_q <= winner_id_d;
    end
  end

  assign player    = player_q;
  assign winner_id = winner_id_q;
  assign armed     = (state_q == StArmed);
  assign locked    = (state_q == StLocked);

endmodule

// File: tb/tb_buzzer_lockout.sv
// Directed and random checks of buzzer_lockout against a sample-history reference model.
module tb_buzzer_lockout;
  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       rst, host_arm, host_clear;
  logic [3:0] buzz;
  logic [3:0] player, foul;
  logic [1:0] winner_id;
  logic       armed, locked;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  buzzer_lockout #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .buzz      (buzz),
    .host_arm  (host_arm),
    .host_clear(host_clear),
    .player    (player),
    .winner_id (winner_id),
    .armed     (armed),
    .locked    (locked),
    .foul      (foul)
  );

  // Reference: a level flips once the last DC synchronized samples all disagree with it.
  logic [3:0] m_s1, m_s2, m_db, m_dbp, m_player, m_foul;
  logic [1:0] m_wid;
  logic       m_armed, m_locked;
  logic [3:0] hist[$];

  task automatic model_edge(input logic r, input logic [3:0] b, input logic a, input logic c);
    logic [3:0] rise, elig, newdb;
    logic       all;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_player = 0; m_foul = 0;
      m_wid = 0; m_armed = 0; m_locked = 0;
      hist.delete();
    end else begin
      rise = m_db & ~m_dbp;
      elig = rise;
`ifdef FALSE_START_EN
      elig = rise & ~m_foul;
`endif
      if (m_locked) begin
        if (c) begin m_locked = 0; m_player = 0; m_wid = 0; m_foul = 0; end
      end else if (m_armed) begin
        if (c) begin
          m_armed = 0; m_foul = 0;
        end else if (elig != 0) begin
          for (int i = 0; i < 4; i++) begin
            if (elig[i] && !m_locked) begin
              m_locked = 1; m_armed = 0; m_player = 4'(1 << i); m_wid = 2'(i);
            end
          end
        end
      end else begin
        if (c) m_foul = 0;
`ifdef FALSE_START_EN
        else m_foul = m_foul | rise;
`endif
        if (a && !c) m_armed = 1;
      end
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      newdb = m_db;
      for (int i = 0; i < 4; i++) begin
        all = (hist.size() == DC);
        foreach (hist[k]) if (hist[k][i] == m_db[i]) all = 0;
        if (all) newdb[i] = ~m_db[i];
      end
      m_dbp = m_db; m_db = newdb; m_s2 = m_s1; m_s1 = b;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] b, input logic a, input logic c);
    rst = r; buzz = b; host_arm = a; host_clear = c;
    @(posedge clk);
    model_edge(r, b, a, c);
    @(negedge clk);
    check("player", player, m_player);
    check("armed", {3'b0, armed}, {3'b0, m_armed});
    check("locked", {3'b0, locked}, {3'b0, m_locked});
    check("foul", foul, m_foul);
    if (m_locked) check("winner_id", {2'b0, winner_id}, {2'b0, m_wid});
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) step(0, b, 0, 0);
  endtask

  initial begin
    logic [3:0] rb;
    int         hcnt;
    rb = 0; hcnt = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_player", player, 4'b0000);
    check("rst_wid", {2'b0, winner_id}, 4'd0);
    check("rst_flags", {foul[1:0], armed, locked}, 4'b0000);

    // Latency: press at edge N, lock at edge N+2+DC.
    step(0, 0, 1, 0);
    for (int k = 0; k <= 6; k++) begin
      step(0, 4'b0100, 0, 0);
      if (k < 6) check("lat_early", {player[2:0], locked}, 4'b0000);
    end
    check("lat_player", player, 4'b0100);
    check("lat_wid", {2'b0, winner_id}, 4'd2);
    check("lat_locked", {3'b0, locked}, 4'd1);
    step(0, 4'b0100, 0, 1);
    hold(0, 8);

    // Glitch rejection, then a real press.
    step(0, 0, 1, 0);
    for (int p = 0; p < 4; p++) begin
      hold(4'b0010, 3);
      hold(4'b0000, 3);
    end
    check("glitch", player, 4'b0000);
    hold(4'b0010, 10);
    check("held", player, 4'b0010);
    step(0, 4'b0010, 0, 1);
    hold(0, 8);

    // Simultaneous rises, lockout, clear.
    step(0, 0, 1, 0);
    hold(4'b1010, 8);
    check("tie_player", player, 4'b0010);
    check("tie_wid", {2'b0, winner_id}, 4'd1);
    hold(4'b0001, 8);
    check("frozen", player, 4'b0010);
    step(0, 4'b0001, 0, 1);
    check("clear_player", player, 4'b0000);
    check("clear_state", {2'b0, armed, locked}, 4'b0000);
    hold(0, 8);

    // Held-through-arm button cannot win.
    hold(4'b1000, 8);
    step(0, 4'b1000, 1, 0);
    hold(4'b1000, 8);
    check("prehold", {3'b0, locked}, 4'd0);
    hold(4'b0000, 4);
    hold(4'b0100, 8);
    check("repress", player, 4'b0100);
    step(0, 0, 0, 1);
    hold(0, 8);

    // Reset mid-round.
    step(0, 0, 1, 0);
    hold(4'b0001, 8);
    check("pre_rst", player, 4'b0001);
    step(1, 0, 0, 0);
    check("mid_rst", {player[1:0], armed, locked}, 4'b0000);
    step(0, 0, 1, 0);
    check("arm_after_rst", {player[2:0], armed}, 4'b0001);
    step(0, 0, 0, 1);
    hold(0, 4);

`ifdef FALSE_START_EN
    hold(4'b0001, 8);
    check("foul_set", foul, 4'b0001);
    hold(0, 8);
    step(0, 0, 1, 0);
    hold(4'b0011, 8);
    check("foul_skip", player, 4'b0010);
    step(0, 4'b0011, 0, 1);
    check("foul_clear", foul, 4'b0000);
    hold(0, 8);
`endif

    for (int n = 0; n < 1500; n++) begin
      if (hcnt == 0) begin
        rb   = 4'($urandom);
        hcnt = $urandom_range(1, 12);
      end
      hcnt--;
      step($urandom_range(0, 199) == 0, rb, $urandom_range(0, 9) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
